// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : freq_pkg
//  Brief    : Shared defaults, range decision encoding and clog2 helper for
//             the frequency-meter prescaler.
//  Revision : 1.0  initial release
// ============================================================================
package freq_pkg;

  localparam int DEF_NRANGE = 4;
  localparam int DEF_DIV    = 10;
  localparam int DEF_CW     = 16;
  localparam int DEF_HI_TH  = 9999;
  localparam int DEF_LO_TH  = 900;

  typedef enum logic [1:0] {
    DEC_HOLD = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DOWN = 2'd2,
    DEC_OVER = 2'd3
  } range_dec_t;

  // Ceiling log2, never below 1 so single-value fields still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/range_div_stage.sv
`default_nettype none
// ============================================================================
//  Module   : range_div_stage
//  Brief    : One decade of the prescaler cascade: mod-DIV counter on e_in,
//             registered wrap strobe and 50% duty toggle output.
//  Revision : 1.0  initial release
// ============================================================================
module range_div_stage
  import freq_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic e_in,
  output logic e_out,
  output logic t_out
);

  localparam int              CNTW = clog2_min1(DIV);
  localparam logic [CNTW-1:0] LAST = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] HALF = CNTW'(DIV / 2 - 1);

  logic [CNTW-1:0] cnt;

  // Toggling at both the half-way point and the wrap gives an even duty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      e_out <= 1'b0;
      t_out <= 1'b0;
    end else begin
      e_out <= e_in && (cnt == LAST);
      if (e_in) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if ((cnt == LAST) || (cnt == HALF)) t_out <= ~t_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/range_autoscale.sv
`default_nettype none
// ============================================================================
//  Module   : range_autoscale
//  Brief    : Multi-decade input prescaler with manual or automatic range
//             selection, edge strobe and overrange flag.
//  Revision : 1.0  initial release
// ============================================================================
module range_autoscale
  import freq_pkg::*;
#(
  parameter  int NRANGE = DEF_NRANGE,
  parameter  int DIV    = DEF_DIV,
  parameter  int CW     = DEF_CW,
  parameter  int HI_TH  = DEF_HI_TH,
  parameter  int LO_TH  = DEF_LO_TH,
  localparam int RW     = clog2_min1(NRANGE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sigin,
  input  logic          auto,
  input  logic [RW-1:0] range_sel,
  input  logic          gate_end,
  output logic          sigout,
  output logic          sig_edge,
  output logic [RW-1:0] range_cur,
  output logic          range_chg,
  output logic          overrange
);

  localparam logic [RW-1:0] TOP  = RW'(NRANGE - 1);
  localparam logic [CW-1:0] WMAX = '1;
  localparam logic [CW-1:0] HI_T = CW'(HI_TH);
  localparam logic [CW-1:0] LO_T = CW'(LO_TH);

  logic              s1, s2, s3;
  logic [NRANGE-1:0] e;
  logic [NRANGE-1:0] t;
  logic [RW-1:0]     sel_clamped;
  logic [CW-1:0]     wcnt;
  range_dec_t        dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sigin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign e[0] = s2 & ~s3;
  assign t[0] = s2;

  generate
    for (genvar k = 1; k < NRANGE; k++) begin : g_stage
      range_div_stage #(
        .DIV (DIV)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .e_in  (e[k-1]),
        .e_out (e[k]),
        .t_out (t[k])
      );
    end
  endgenerate

  assign sel_clamped = (range_sel >= TOP) ? TOP : range_sel;

  always_comb begin
    dec = DEC_HOLD;
    if (wcnt > HI_T) begin
      dec = (range_cur == TOP) ? DEC_OVER : DEC_UP;
    end else if ((wcnt < LO_T) && (range_cur != '0)) begin
      dec = DEC_DOWN;
    end
  end

  // A pending range_chg clears the window so a count spanning a change is never decided on.
  always_ff @(posedge clk) begin
    if (rst) begin
      sigout    <= 1'b0;
      sig_edge  <= 1'b0;
      range_cur <= '0;
      range_chg <= 1'b0;
      overrange <= 1'b0;
      wcnt      <= '0;
    end else begin
      sigout    <= t[range_cur];
      sig_edge  <= e[range_cur];
      range_chg <= 1'b0;
      if (!auto) begin
        overrange <= 1'b0;
        wcnt      <= '0;
        if (range_cur != sel_clamped) begin
          range_cur <= sel_clamped;
          range_chg <= 1'b1;
        end
      end else if (gate_end) begin
        wcnt <= sig_edge ? CW'(1) : '0;
        case (dec)
          DEC_UP: begin
            range_cur <= range_cur + 1'b1;
            range_chg <= 1'b1;
            overrange <= 1'b0;
          end
          DEC_DOWN: begin
            range_cur <= range_cur - 1'b1;
            range_chg <= 1'b1;
            overrange <= 1'b0;
          end
          DEC_OVER: overrange <= 1'b1;
          default:  overrange <= 1'b0;
        endcase
      end else if (range_chg) begin
        wcnt <= '0;
      end else if (sig_edge && (wcnt != WMAX)) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
